// File: rtl/adc_acq_pkg.sv
// Shared types and field widths for the ADC acquisition sequencer.
package adc_acq_pkg;

   localparam int unsigned CYC_PER_WORD = 4;
   localparam int unsigned TYPE_W       = 2;
   localparam int unsigned NUM_W        = 21;
   localparam int unsigned ADR_W        = 23;
   localparam int unsigned FILL_NUM_W   = 24;
   localparam int unsigned MISS_W       = 8;

   localparam logic [TYPE_W-1:0] FILL_NONE = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      HEADER,
      DATA,
      CHECKSUM,
      DONE
   } state_t;

endpackage

// File: rtl/adc_acq_sequencer.sv
// Sequences one fill (header, N data words, checksum) through the ADC output mux
// and produces the FIFO write strobe aligned to the mux's registered output.
module adc_acq_sequencer
   import adc_acq_pkg::*;
#(
   parameter int unsigned CYC_PER_WORD = adc_acq_pkg::CYC_PER_WORD,
   parameter int unsigned ADR_W        = adc_acq_pkg::ADR_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  trigger,
   input  logic [TYPE_W-1:0]     fill_type_in,
   input  logic [NUM_W-1:0]      num_bursts_in,
   input  logic                  fifo_full,
   output logic                  select_dat,
   output logic                  select_checksum,
   output logic [TYPE_W-1:0]     fill_type,
   output logic [NUM_W-1:0]      num_fill_bursts,
   output logic [ADR_W-1:0]      burst_start_adr,
   output logic [FILL_NUM_W-1:0] fill_num,
   output logic                  fifo_wr_en,
   output logic                  busy,
   output logic                  fill_done,
   output logic                  overflow_err,
   output logic [MISS_W-1:0]     missed_trig
);

   localparam int unsigned PH_W = $clog2(CYC_PER_WORD);

   state_t           state;
   logic [PH_W-1:0]  phase;
   logic [NUM_W-1:0] word_cnt;
   logic             want_wr_c;

   // Cycles whose mux output must be written one clock later.
   always_comb begin
      want_wr_c = 1'b0;
      if (state == HEADER || state == CHECKSUM)
         want_wr_c = 1'b1;
      else if (state == DATA && phase == '0)
         want_wr_c = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         phase           <= '0;
         word_cnt        <= '0;
         select_dat      <= 1'b0;
         select_checksum <= 1'b0;
         fill_type       <= '0;
         num_fill_bursts <= '0;
         burst_start_adr <= '0;
         fill_num        <= '0;
         fifo_wr_en      <= 1'b0;
         busy            <= 1'b0;
         fill_done       <= 1'b0;
         overflow_err    <= 1'b0;
         missed_trig     <= '0;
      end else begin
         // The stream cannot stall: a full FIFO drops the word and flags it.
         fifo_wr_en <= want_wr_c & ~fifo_full;
         if (want_wr_c && fifo_full)
            overflow_err <= 1'b1;
         fill_done <= 1'b0;
         if (busy && trigger && missed_trig != '1)
            missed_trig <= missed_trig + MISS_W'(1);

         case (state)
            IDLE: begin
               if (trigger && fill_type_in != FILL_NONE) begin
                  fill_type       <= fill_type_in;
                  num_fill_bursts <= num_bursts_in;
                  busy            <= 1'b1;
                  state           <= HEADER;
               end
            end
            HEADER: begin
               // Phase starts at 1 to track the mux counter loaded during HEADER.
               phase    <= PH_W'(1);
               word_cnt <= '0;
               if (num_fill_bursts != '0) begin
                  select_dat <= 1'b1;
                  state      <= DATA;
               end else begin
                  select_checksum <= 1'b1;
                  state           <= CHECKSUM;
               end
            end
            DATA: begin
               phase <= phase + PH_W'(1);
               if (phase == '0) begin
                  word_cnt <= word_cnt + NUM_W'(1);
                  if (word_cnt == num_fill_bursts - NUM_W'(1)) begin
                     select_dat      <= 1'b0;
                     select_checksum <= 1'b1;
                     state           <= CHECKSUM;
                  end
               end
            end
            CHECKSUM: begin
               select_checksum <= 1'b0;
               fill_done       <= 1'b1;
               fill_num        <= fill_num + FILL_NUM_W'(1);
               burst_start_adr <= burst_start_adr + ADR_W'(num_fill_bursts) + ADR_W'(2);
               state           <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Self-checking bench for adc_acq_sequencer with a cycle-schedule reference model and a mux model.
module tb_adc_acq_sequencer;

   logic          clk;
   logic          reset;
   logic          trigger;
   logic [1:0]    fill_type_in;
   logic [20:0]   num_bursts_in;
   logic          fifo_full;
   logic          select_dat;
   logic          select_checksum;
   logic [1:0]    fill_type;
   logic [20:0]   num_fill_bursts;
   logic [22:0]   burst_start_adr;
   logic [23:0]   fill_num;
   logic          fifo_wr_en;
   logic          busy;
   logic          fill_done;
   logic          overflow_err;
   logic [7:0]    missed_trig;

   adc_acq_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .trigger         (trigger),
      .fill_type_in    (fill_type_in),
      .num_bursts_in   (num_bursts_in),
      .fifo_full       (fifo_full),
      .select_dat      (select_dat),
      .select_checksum (select_checksum),
      .fill_type       (fill_type),
      .num_fill_bursts (num_fill_bursts),
      .burst_start_adr (burst_start_adr),
      .fill_num        (fill_num),
      .fifo_wr_en      (fifo_wr_en),
      .busy            (busy),
      .fill_done       (fill_done),
      .overflow_err    (overflow_err),
      .missed_trig     (missed_trig)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model: fill schedule derived from the trigger cycle and N.
   int          m_cyc = 0;
   bit          m_active = 1'b0;
   int          m_t = 0;
   int          m_n = 0;
   logic [1:0]  m_type = '0;
   logic [20:0] m_nb = '0;
   logic [23:0] m_fnum = '0;
   logic [22:0] m_adr = '0;
   int          m_missed = 0;
   bit          m_ovf = 1'b0;
   bit          m_pfull = 1'b0;
   bit          m_prst = 1'b1;
   bit          m_busy_now = 1'b0;

   int str_q[$];
   int done_q[$];
   logic [127:0] fifo_q[$];

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, m_cyc, act, exp);
      end
   endfunction

   function automatic logic [127:0] ramp(int k);
      logic [127:0] r;
      r = '0;
      for (int s = 0; s < 8; s++) r[16*s +: 16] = 16'(8*k + s);
      return r;
   endfunction

   // Mux model: header seeds checksum, data words XOR in on its counter==0, checksum word on select.
   logic [127:0] mux_out = '0;
   logic [127:0] csum = '0;
   logic [1:0]   mcnt = '0;
   int           widx = 0;
   logic [127:0] hdr;
   assign hdr = 128'({fill_num, burst_start_adr, fill_type, num_fill_bursts});

   always @(posedge clk) begin
      if (fifo_wr_en) fifo_q.push_back(mux_out);
      if (select_checksum) begin
         mux_out <= csum;
      end else if (select_dat) begin
         if (mcnt == 2'd0) begin
            mux_out <= ramp(widx);
            csum    <= csum ^ ramp(widx);
            widx    <= widx + 1;
         end
         mcnt <= mcnt + 2'd1;
      end else begin
         mux_out <= hdr;
         csum    <= hdr;
         mcnt    <= 2'd1;
         widx    <= 0;
      end
   end

   function automatic void model_check();
      int  rel;
      int  e;
      bit  b, sd, sc, d, w;
      if (m_prst) begin
         m_active = 1'b0; m_fnum = '0; m_adr = '0; m_type = '0; m_nb = '0;
         m_missed = 0; m_ovf = 1'b0;
      end
      rel = m_cyc - m_t;
      e   = 4*m_n + 3;
      b   = m_active && rel >= 1 && rel <= e;
      sd  = m_active && m_n > 0 && rel >= 2 && rel <= e - 2;
      sc  = m_active && rel == e - 1;
      d   = m_active && rel == e;
      w   = m_active && (rel == 2 || rel == e ||
                         (m_n > 0 && rel >= 6 && rel <= e - 1 && (rel - 2) % 4 == 0));
      if (d) begin
         m_fnum = m_fnum + 24'd1;
         m_adr  = m_adr + 23'(m_n + 2);
      end
      if (w && m_pfull) m_ovf = 1'b1;
      m_busy_now = b;
      chk("busy", 128'(busy), 128'(b));
      chk("select_dat", 128'(select_dat), 128'(sd));
      chk("select_checksum", 128'(select_checksum), 128'(sc));
      chk("fill_done", 128'(fill_done), 128'(d));
      chk("fifo_wr_en", 128'(fifo_wr_en), 128'(w && !m_pfull));
      chk("overflow_err", 128'(overflow_err), 128'(m_ovf));
      chk("missed_trig", 128'(missed_trig), 128'(m_missed));
      chk("fill_num", 128'(fill_num), 128'(m_fnum));
      chk("burst_start_adr", 128'(burst_start_adr), 128'(m_adr));
      chk("fill_type", 128'(fill_type), 128'(m_type));
      chk("num_fill_bursts", 128'(num_fill_bursts), 128'(m_nb));
   endfunction

   function automatic void model_update(bit trig, logic [1:0] ty, logic [20:0] nb, bit full, bit rst);
      if (!rst && trig) begin
         if (m_busy_now) begin
            if (m_missed < 255) m_missed++;
         end else if (ty != 2'b00) begin
            m_active = 1'b1; m_t = m_cyc; m_n = int'(nb); m_type = ty; m_nb = nb;
         end
      end
      m_pfull = full;
      m_prst  = rst;
      m_cyc++;
   endfunction

   task automatic step(input bit trig, input logic [1:0] ty, input logic [20:0] nb,
                       input bit full, input bit rst);
      @(posedge clk);
      #1;
      trigger = trig; fill_type_in = ty; num_bursts_in = nb; fifo_full = full; reset = rst;
      @(negedge clk);
      model_check();
      if (fifo_wr_en) str_q.push_back(m_cyc);
      if (fill_done) done_q.push_back(m_cyc);
      model_update(trig, ty, nb, full, rst);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 21'd0, 1'b0, 1'b0);
   endtask

   // One trigger followed by enough cycles to finish; full_rel marks the cycle fifo_full is high.
   task automatic run_fill(input logic [1:0] ty, input int n, input int full_rel, output int t0);
      str_q.delete();
      done_q.delete();
      t0 = m_cyc;
      step(1'b1, ty, 21'(n), full_rel == 0, 1'b0);
      for (int i = 1; i < 4*n + 8; i++) step(1'b0, ty, 21'(n), i == full_rel, 1'b0);
   endtask

   typedef struct {
      logic [1:0] ty;
      int         n;
      int         full_rel;
      int         exp_strobes;
      int         exp_dones;
      int         exp_adr_delta;
      bit         exp_ovf;
   } vec_t;

   vec_t vt[5];

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", m_cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int exp_rel[4];
      logic [22:0] adr0;
      logic [127:0] h, x;

      vt[0] = '{2'b01, 2, -1, 4, 1, 4, 1'b0};
      vt[1] = '{2'b10, 0, -1, 2, 1, 2, 1'b0};
      vt[2] = '{2'b11, 3, -1, 5, 1, 5, 1'b0};
      vt[3] = '{2'b00, 4, -1, 0, 0, 0, 1'b0};
      vt[4] = '{2'b01, 3,  9, 4, 1, 5, 1'b1};
      exp_rel = '{2, 6, 10, 11};

      reset = 1'b1; trigger = 1'b0; fill_type_in = '0; num_bursts_in = '0; fifo_full = 1'b0;
      step(1'b0, 2'b00, 21'd0, 1'b0, 1'b1);
      step(1'b0, 2'b00, 21'd0, 1'b0, 1'b1);
      idle(7);

      // Table of single fills; entry 4 blocks the second data strobe.
      for (int v = 0; v < 5; v++) begin
         adr0 = burst_start_adr;
         run_fill(vt[v].ty, vt[v].n, vt[v].full_rel, t0);
         chk("vec_strobes", 128'(str_q.size()), 128'(vt[v].exp_strobes));
         chk("vec_dones", 128'(done_q.size()), 128'(vt[v].exp_dones));
         chk("vec_adr_delta", 128'(23'(burst_start_adr - adr0)), 128'(vt[v].exp_adr_delta));
         chk("vec_ovf", 128'(overflow_err), 128'(vt[v].exp_ovf));
         if (v == 0) begin
            for (int k = 0; k < 4; k++)
               chk("n2_strobe_time", 128'(str_q.size() > k ? str_q[k] - t0 : -1), 128'(exp_rel[k]));
            chk("n2_done_time", 128'(done_q.size() > 0 ? done_q[0] - t0 : -1), 128'(11));
            chk("n2_fill_num", 128'(fill_num), 128'(1));
         end
         if (v == 4) begin
            chk("blk_strobe1", 128'(str_q.size() > 2 ? str_q[2] - t0 : -1), 128'(14));
            chk("blk_strobe2", 128'(str_q.size() > 3 ? str_q[3] - t0 : -1), 128'(15));
         end
         idle(3);
      end

      // Mux in the loop, N=3 ramp data.
      h = 128'({m_fnum, m_adr, 2'b10, 21'd3});
      fifo_q.delete();
      run_fill(2'b10, 3, -1, t0);
      x = h ^ ramp(0) ^ ramp(1) ^ ramp(2);
      chk("mux_words", 128'(fifo_q.size()), 128'(5));
      if (fifo_q.size() == 5) begin
         chk("mux_header", fifo_q[0], h);
         for (int k = 0; k < 3; k++) chk("mux_data", fifo_q[k+1], ramp(k));
         chk("mux_checksum", fifo_q[4], x);
      end

      // N=0 through the mux: checksum equals header.
      h = 128'({m_fnum, m_adr, 2'b01, 21'd0});
      fifo_q.delete();
      run_fill(2'b01, 0, -1, t0);
      chk("n0_words", 128'(fifo_q.size()), 128'(2));
      if (fifo_q.size() == 2) begin
         chk("n0_header", fifo_q[0], h);
         chk("n0_checksum", fifo_q[1], h);
      end

      // Trigger with fill type 00 in IDLE does nothing.
      str_q.delete();
      step(1'b1, 2'b00, 21'd5, 1'b0, 1'b0);
      idle(10);
      chk("none_strobes", 128'(str_q.size()), 128'(0));

      // Long fill with 300 triggers while busy.
      done_q.delete();
      step(1'b1, 2'b01, 21'd1000, 1'b0, 1'b0);
      for (int i = 1; i < 4010; i++)
         step(i % 13 == 1 && i <= 3888, 2'b01, 21'd1000, 1'b0, 1'b0);
      chk("sat_missed", 128'(missed_trig), 128'(255));
      chk("sat_done", 128'(done_q.size()), 128'(1));

      // Reset in the middle of DATA.
      step(1'b1, 2'b01, 21'd5, 1'b0, 1'b0);
      idle(7);
      step(1'b0, 2'b00, 21'd0, 1'b0, 1'b1);
      str_q.delete();
      done_q.delete();
      idle(30);
      chk("rst_strobes", 128'(str_q.size()), 128'(0));
      chk("rst_fill_num", 128'(fill_num), 128'(0));
      chk("rst_ovf", 128'(overflow_err), 128'(0));
      run_fill(2'b01, 1, -1, t0);
      chk("rst_refill_strobes", 128'(str_q.size()), 128'(3));
      chk("rst_refill_num", 128'(fill_num), 128'(1));
      idle(2);

      // Counter wrap from preset values.
      force dut.fill_num = 24'hFFFFFF;
      force dut.burst_start_adr = 23'h7FFFFE;
      #1;
      release dut.fill_num;
      release dut.burst_start_adr;
      m_fnum = 24'hFFFFFF;
      m_adr  = 23'h7FFFFE;
      run_fill(2'b01, 3, -1, t0);
      chk("wrap_fill_num", 128'(fill_num), 128'(0));
      chk("wrap_adr", 128'(burst_start_adr), 128'(3));

      // Randomized traffic against the model.
      for (int i = 0; i < 1500; i++)
         step(($urandom % 6) == 0, 2'($urandom_range(0, 3)), 21'($urandom_range(0, 5)),
              ($urandom % 16) == 0, ($urandom % 400) == 0);
      idle(30);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/adc_acq_sequencer.md
Name: adc_acq_sequencer

Overview:
- Control stage directly upstream of the ADC header/data/checksum output mux. Drives that mux's select_dat/select_checksum lines and supplies its fill_num, burst_start_adr and num_fill_bursts fields.
- Produces the DDR3 write-FIFO write strobe aligned to the mux's registered 128-bit output.
- One fill on the FIFO is: 1 header word, N data words (8 samples each, one every 4 clocks), 1 checksum word.

Parameters:
- CYC_PER_WORD, 4, clocks per 128-bit data word; fixed by the mux's 2-bit checksum counter, so only 4 is legal.
- ADR_W, 23, burst address width.

Ports:
- clk  in  1  ADC-domain clock
- reset  in  1  synchronous, active-high
- trigger  in  1  single-cycle fill request
- fill_type_in  in  2  fill type; 2'b00 means no fill (trigger ignored)
- num_bursts_in  in  21  N, data words per fill
- fifo_full  in  1  DDR3 write FIFO full
- select_dat  out  1  to mux; 1 = data
- select_checksum  out  1  to mux; 1 = checksum
- fill_type  out  2  latched fill type, to mux
- num_fill_bursts  out  21  latched N, to mux
- burst_start_adr  out  23  start address of current fill, to mux
- fill_num  out  24  current fill number, to mux
- fifo_wr_en  out  1  write strobe for the mux output
- busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse after checksum is written
- overflow_err  out  1  sticky; a word was dropped
- missed_trig  out  8  saturating count of ignored triggers

Behaviour:
- Reset values: select_dat=0, select_checksum=0, fifo_wr_en=0, busy=0, fill_done=0, overflow_err=0, missed_trig=0, fill_num=0, burst_start_adr=0, fill_type=0, num_fill_bursts=0.
- Reset mid-fill aborts the fill immediately. No checksum is written and fill_num does not advance.
- All outputs are registered.
- States: IDLE, HEADER, DATA, CHECKSUM, DONE.
- IDLE:
  - select_dat=0 and select_checksum=0, which keeps the mux checksum seeded with the header.
  - On trigger with fill_type_in!=0: latch fill_type_in and num_bursts_in, then go to HEADER.
  - On trigger with fill_type_in==0: stay in IDLE.
- HEADER: exactly 1 cycle, selects 00. Go to DATA if N>0, else go to CHECKSUM.
- DATA:
  - select_dat=1 for exactly 4N cycles; a 2-bit phase counter runs 1,2,3,0,1,...
  - The phase starts at 1 in the first DATA cycle, matching the mux counter, which is loaded to 1 during HEADER.
  - A 21-bit word counter increments on each phase==0 cycle. Leave DATA after the phase==0 cycle of word N.
- CHECKSUM: 1 cycle with select_checksum=1 and select_dat=0. Then go to DONE.
- DONE: 1 cycle.
  - fill_done=1, fill_num increments (24-bit, wraps to 0).
  - burst_start_adr += N+2, modulo 2^23.
  - Return to IDLE.
- Write strobe:
  - fifo_wr_en=1 exactly one cycle after each of: the HEADER cycle, every DATA cycle with phase==0, and the CHECKSUM cycle. This accounts for the mux's 1-cycle register.
  - Total strobes per fill = N+2.
- Latency: trigger at cycle t gives HEADER at t+1, header strobe at t+2, first data strobe at t+6, checksum strobe at t+4N+3, fill_done at t+4N+3.
- busy=1 from the HEADER cycle through DONE inclusive.
- Backpressure: the ADC stream cannot stall.
  - If fifo_full=1 in a cycle where fifo_wr_en would assert, suppress the strobe and set overflow_err.
  - The sequence continues unchanged.
  - overflow_err clears only on reset.
- Trigger while busy=1 is ignored and increments missed_trig, saturating at 255.
- Trigger in the DONE cycle counts as missed.
- A trigger in the IDLE cycle after DONE is accepted (back-to-back fills allowed).
- fill_num, burst_start_adr, fill_type and num_fill_bursts are stable from HEADER through CHECKSUM.

Decomposition:
- Shared package adc_acq_pkg holds:
  - state enum {IDLE, HEADER, DATA, CHECKSUM, DONE}
  - CYC_PER_WORD=4
  - FILL_NONE=2'b00
  - field widths: 21, 23, 24
- Single module; no sub-module required. The phase and word counters stay inline.

Test Plan:
- N=2, fill_type=01, trigger at t=10, fifo_full=0: exactly 4 strobes, at t=12, 16, 20, 21; fill_done at t=21; fill_num 0→1; burst_start_adr 0→4; select_dat high t=12..19.
- N=0 trigger: HEADER then CHECKSUM; 2 strobes at t+2 and t+3; burst_start_adr += 2. With the real mux attached, the checksum word equals the header word.
- Mux-in-loop with a data pattern: the FIFO receives the header, N data words, and a checksum equal to the header XOR all N data words. N=3, ramp data.
- fifo_full held high for the second data strobe only: that strobe is suppressed, overflow_err=1 and remains set; the remaining strobes are unchanged; fill_done still occurs.
- 300 triggers during a long fill (N=1000): missed_trig saturates at 255; the fill completes normally. A trigger with fill_type_in=00 in IDLE produces no activity.
- Reset asserted in mid-DATA: next cycle all outputs are at reset values; no checksum strobe; fill_num=0; a new trigger starts a clean fill. Separately, fill_num and burst_start_adr wrap: fill_num preset to 2^24-1 wraps to 0 after one fill.
